// File: rtl/fsm_ascon_dec_if.sv
// Signal bundle between the ASCON decrypt sequencer and its environment (host + ASCON core).
// master drives frame/core-status inputs; slave is the sequencer itself.
interface fsm_ascon_dec_if;
  logic            start_i;
  logic [1471:0]   cipher_i;
  logic [127:0]    tag_i;
  logic [63:0]     associate_data_i;
  logic            end_initialisation_i;
  logic            end_associate_i;
  logic            cipher_valid_i;
  logic            end_cipher_i;
  logic            end_tag_i;
  logic [63:0]     core_data_i;
  logic [127:0]    tag_computed_i;

  logic            init_o;
  logic            associate_data_o;
  logic            finalisation_o;
  logic            data_valid_o;
  logic            decrypt_o;
  logic [63:0]     data_o;
  logic [1471:0]   plain_o;
  logic            done_o;
  logic            tag_ok_o;

  modport master (
    output start_i, cipher_i, tag_i, associate_data_i,
    output end_initialisation_i, end_associate_i, cipher_valid_i, end_cipher_i, end_tag_i,
    output core_data_i, tag_computed_i,
    input  init_o, associate_data_o, finalisation_o, data_valid_o, decrypt_o,
    input  data_o, plain_o, done_o, tag_ok_o
  );

  modport slave (
    input  start_i, cipher_i, tag_i, associate_data_i,
    input  end_initialisation_i, end_associate_i, cipher_valid_i, end_cipher_i, end_tag_i,
    input  core_data_i, tag_computed_i,
    output init_o, associate_data_o, finalisation_o, data_valid_o, decrypt_o,
    output data_o, plain_o, done_o, tag_ok_o
  );
endinterface

// File: rtl/fsm_ascon_dec.sv
// Sequences an ASCON core through one 23-block decrypt frame, assembles plaintext and checks the tag.
// Each step waits on the core's status pulse; control outputs decode from registered state only.
module fsm_ascon_dec (
  input  logic          clock_i,
  input  logic          reset_i,
  fsm_ascon_dec_if.slave bus
);
  localparam int          NBLK      = 23;
  localparam logic [4:0]  LAST_CNT  = 5'd23;
  localparam logic [63:0] FINAL_PAD = 64'h8000_0000_0000_0000;

  typedef enum logic [3:0] {
    S_IDLE,
    S_INIT,
    S_WAIT_INIT,
    S_AD,
    S_AD_VALID,
    S_WAIT_AD,
    S_CT_SET,
    S_CT_WAIT_VALID,
    S_CT_GET,
    S_CT_WAIT_END,
    S_FINAL,
    S_WAIT_TAG,
    S_CHECK,
    S_DONE
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [4:0]     blk_cnt;
  logic [1471:0]  plain_q;
  logic           tag_ok_q;
  logic [63:0]    cipher_blk;
  logic           tag_match;

  assign tag_match = (bus.tag_computed_i == bus.tag_i);

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Pulses seen in any state other than the one waiting for them fall through the defaults.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:          if (bus.start_i) state_nxt = S_INIT;
      S_INIT:          state_nxt = S_WAIT_INIT;
      S_WAIT_INIT:     if (bus.end_initialisation_i) state_nxt = S_AD;
      S_AD:            state_nxt = S_AD_VALID;
      S_AD_VALID:      state_nxt = S_WAIT_AD;
      S_WAIT_AD:       if (bus.end_associate_i) state_nxt = S_CT_SET;
      S_CT_SET:        state_nxt = S_CT_WAIT_VALID;
      S_CT_WAIT_VALID: if (bus.cipher_valid_i) state_nxt = S_CT_GET;
      S_CT_GET:        state_nxt = S_CT_WAIT_END;
      S_CT_WAIT_END: begin
        if (bus.end_cipher_i) begin
          state_nxt = (blk_cnt == LAST_CNT) ? S_FINAL : S_CT_SET;
        end
      end
      S_FINAL:         if (bus.cipher_valid_i) state_nxt = S_WAIT_TAG;
      S_WAIT_TAG:      if (bus.end_tag_i) state_nxt = S_CHECK;
      S_CHECK:         state_nxt = S_DONE;
      S_DONE:          if (!bus.start_i) state_nxt = S_IDLE;
      default:         state_nxt = S_IDLE;
    endcase
  end

  // Block 0 sits in the top 64 bits of the frame; counts past the last block select nothing.
  always_comb begin
    cipher_blk = '0;
    for (int k = 0; k < NBLK; k++) begin
      if (blk_cnt == 5'(k)) begin
        cipher_blk = bus.cipher_i[1471 - 64*k -: 64];
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      blk_cnt  <= '0;
      plain_q  <= '0;
      tag_ok_q <= 1'b0;
    end else begin
      case (state)
        S_INIT: begin
          blk_cnt  <= '0;
          plain_q  <= '0;
          tag_ok_q <= 1'b0;
        end
        S_CT_GET: begin
          if (blk_cnt < LAST_CNT) begin
            for (int k = 0; k < NBLK; k++) begin
              if (blk_cnt == 5'(k)) begin
                plain_q[1471 - 64*k -: 64] <= bus.core_data_i;
              end
            end
            blk_cnt <= blk_cnt + 5'd1;
          end
        end
        S_CHECK: begin
          // Unauthenticated plaintext never becomes visible in DONE.
          tag_ok_q <= tag_match;
          if (!tag_match) begin
            plain_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.init_o           = 1'b0;
    bus.associate_data_o = 1'b0;
    bus.finalisation_o   = 1'b0;
    bus.data_valid_o     = 1'b0;
    bus.decrypt_o        = 1'b0;
    bus.done_o           = 1'b0;
    bus.data_o           = '0;
    case (state)
      S_INIT: begin
        bus.init_o    = 1'b1;
        bus.decrypt_o = 1'b1;
      end
      S_WAIT_INIT: bus.decrypt_o = 1'b1;
      S_AD: begin
        bus.associate_data_o = 1'b1;
        bus.decrypt_o        = 1'b1;
        bus.data_o           = bus.associate_data_i;
      end
      S_AD_VALID: begin
        bus.associate_data_o = 1'b1;
        bus.data_valid_o     = 1'b1;
        bus.decrypt_o        = 1'b1;
        bus.data_o           = bus.associate_data_i;
      end
      S_WAIT_AD: begin
        bus.decrypt_o = 1'b1;
        bus.data_o    = bus.associate_data_i;
      end
      S_CT_SET: begin
        bus.data_valid_o = 1'b1;
        bus.decrypt_o    = 1'b1;
        bus.data_o       = cipher_blk;
      end
      S_CT_WAIT_VALID, S_CT_GET, S_CT_WAIT_END: begin
        bus.decrypt_o = 1'b1;
        bus.data_o    = cipher_blk;
      end
      S_FINAL, S_WAIT_TAG: begin
        bus.finalisation_o = 1'b1;
        bus.data_valid_o   = 1'b1;
        bus.decrypt_o      = 1'b1;
        bus.data_o         = FINAL_PAD;
      end
      S_DONE: bus.done_o = 1'b1;
      default: ;
    endcase
  end

  assign bus.plain_o  = plain_q;
  assign bus.tag_ok_o = tag_ok_q;

endmodule

// File: tb/tb_fsm_ascon_dec.sv
// Drives fsm_ascon_dec against a 3-cycle-latency ASCON core model and a plaintext/tag reference.
module tb_fsm_ascon_dec;
  logic clock_i = 1'b0;
  logic reset_i;

  always #5 clock_i = ~clock_i;

  fsm_ascon_dec_if bus ();

  fsm_ascon_dec dut (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .bus     (bus)
  );

  int total  = 0;
  int passed = 0;
  int fails  = 0;

  logic [63:0] ct [23];
  logic [63:0] ks [23];

  localparam int LAT = 3;
  localparam int EV_NONE = 0, EV_INIT = 1, EV_AD = 2, EV_CV = 3, EV_EC = 4, EV_FCV = 5, EV_ET = 6;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_pulses();
    bus.end_initialisation_i = 1'b0;
    bus.end_associate_i      = 1'b0;
    bus.cipher_valid_i       = 1'b0;
    bus.end_cipher_i         = 1'b0;
    bus.end_tag_i            = 1'b0;
  endtask

  task automatic load_frame(input bit pattern);
    for (int k = 0; k < 23; k++) begin
      logic [7:0] kb;
      kb    = 8'(k);
      ct[k] = pattern ? {8{kb}} : {$urandom, $urandom};
      ks[k] = {$urandom, $urandom};
      bus.cipher_i[1471 - 64*k -: 64] = ct[k];
    end
    bus.associate_data_i = {$urandom, $urandom};
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_init"},     bus.init_o, 1'b0);
    chk({tag, "_decrypt"},  bus.decrypt_o, 1'b0);
    chk({tag, "_dvalid"},   bus.data_valid_o, 1'b0);
    chk({tag, "_done"},     bus.done_o, 1'b0);
    chk({tag, "_data"},     bus.data_o, 64'd0);
    chk({tag, "_plain_nz"}, |bus.plain_o, 1'b0);
  endtask

  // rst_blk >= 0 asserts reset when the core is offered block rst_blk (i.e. rst_blk blocks done).
  task automatic run_frame(input string name, input bit bad_tag, input bit spurious,
                           input int rst_blk, input int hold_extra);
    int          ev, cnt, cyc, ct_seen, init_cnt, idx;
    bit          done_seen, fin_seen, ad_seen;
    logic [63:0] pend, fin_val;
    logic [63:0] dseq [$];
    logic [127:0] tag_ref;

    ev = EV_NONE; cnt = 0; cyc = 0; ct_seen = 0; init_cnt = 0;
    done_seen = 0; fin_seen = 0; ad_seen = 0; pend = '0; fin_val = '0;
    tag_ref            = {$urandom, $urandom, $urandom, $urandom};
    bus.tag_i          = bad_tag ? (tag_ref ^ 128'd1) : tag_ref;
    bus.tag_computed_i = ~tag_ref;
    bus.start_i        = 1'b1;

    while (cyc < 3000) begin
      @(negedge clock_i);
      cyc++;
      clear_pulses();
      if (bus.done_o) begin
        done_seen = 1;
        break;
      end
      if (ev != EV_NONE) begin
        cnt--;
        if (cnt == 0) begin
          case (ev)
            EV_INIT: begin bus.end_initialisation_i = 1'b1; ev = EV_NONE; end
            EV_AD:   begin bus.end_associate_i = 1'b1; ev = EV_NONE; end
            EV_CV:   begin
              bus.cipher_valid_i = 1'b1; bus.core_data_i = pend; ev = EV_EC; cnt = LAT;
            end
            EV_EC:   begin bus.end_cipher_i = 1'b1; ev = EV_NONE; end
            EV_FCV:  begin bus.cipher_valid_i = 1'b1; ev = EV_ET; cnt = LAT; end
            EV_ET:   begin bus.end_tag_i = 1'b1; bus.tag_computed_i = tag_ref; ev = EV_NONE; end
            default: ev = EV_NONE;
          endcase
        end
      end
      if (bus.init_o) begin
        init_cnt++;
        if (hold_extra == 0) bus.start_i = 1'b0;
        ev = EV_INIT; cnt = LAT;
      end
      if (bus.data_valid_o && bus.associate_data_o && !ad_seen) begin
        ad_seen = 1;
        chk({name, "_ad_data"}, bus.data_o, bus.associate_data_i);
        ev = EV_AD; cnt = LAT;
      end
      if (bus.data_valid_o && !bus.associate_data_o && !bus.finalisation_o) begin
        idx = ct_seen;
        ct_seen++;
        if (rst_blk >= 0 && idx == rst_blk) begin
          chk({name, "_pre_rst_plain_nz"}, |bus.plain_o, 1'b1);
          reset_i = 1'b1;
          bus.start_i = 1'b0;
          @(negedge clock_i);
          clear_pulses();
          check_idle_outputs({name, "_midrst"});
          chk({name, "_midrst_tagok"}, bus.tag_ok_o, 1'b0);
          reset_i = 1'b0;
          @(negedge clock_i);
          return;
        end
        dseq.push_back(bus.data_o);
        pend = bus.data_o ^ ks[idx % 23];
        if (spurious) bus.end_cipher_i = 1'b1;
        ev = EV_CV; cnt = LAT;
      end
      if (bus.data_valid_o && bus.finalisation_o && !fin_seen) begin
        fin_seen = 1;
        fin_val  = bus.data_o;
        ev = EV_FCV; cnt = LAT;
      end
    end

    chk({name, "_reached_done"}, done_seen, 1'b1);
    if (!done_seen) begin
      bus.start_i = 1'b0;
      return;
    end
    chk({name, "_ct_blocks"}, ct_seen, 23);
    chk({name, "_final_pad"}, fin_val, 64'h8000_0000_0000_0000);
    chk({name, "_tag_ok"}, bus.tag_ok_o, !bad_tag);
    for (int k = 0; k < 23; k++) begin
      logic [63:0] exp_p;
      exp_p = bad_tag ? 64'd0 : (ct[k] ^ ks[k]);
      chk($sformatf("%s_plain_blk%0d", name, k), bus.plain_o[1471 - 64*k -: 64], exp_p);
      if (k < dseq.size()) chk($sformatf("%s_order_blk%0d", name, k), dseq[k], ct[k]);
    end

    if (hold_extra > 0) begin
      int bad_done;
      bad_done = 0;
      for (int i = 0; i < hold_extra; i++) begin
        @(negedge clock_i);
        if (!bus.done_o) bad_done++;
        if (bus.init_o) init_cnt++;
      end
      chk({name, "_held_done_cycles_lost"}, bad_done, 0);
      chk({name, "_held_single_init"}, init_cnt, 1);
      bus.start_i = 1'b0;
      @(negedge clock_i);
      chk({name, "_released_done"}, bus.done_o, 1'b0);
    end else begin
      repeat (3) @(negedge clock_i);
      chk({name, "_idle_done"}, bus.done_o, 1'b0);
      chk({name, "_idle_tag_hold"}, bus.tag_ok_o, !bad_tag);
      chk({name, "_idle_no_restart"}, bus.decrypt_o, 1'b0);
    end
  endtask

  initial begin
    reset_i              = 1'b1;
    bus.start_i          = 1'b0;
    bus.cipher_i         = '0;
    bus.tag_i            = '0;
    bus.associate_data_i = '0;
    bus.core_data_i      = '0;
    bus.tag_computed_i   = '0;
    clear_pulses();

    repeat (3) @(negedge clock_i);
    check_idle_outputs("reset");
    chk("reset_tag_ok", bus.tag_ok_o, 1'b0);
    chk("reset_final", bus.finalisation_o, 1'b0);
    chk("reset_assoc", bus.associate_data_o, 1'b0);
    reset_i = 1'b0;
    @(negedge clock_i);

    // end_tag_i while idle must not move the sequencer.
    bus.end_tag_i = 1'b1;
    @(negedge clock_i);
    bus.end_tag_i = 1'b0;
    @(negedge clock_i);
    check_idle_outputs("spur_idle");

    load_frame(1'b0);
    run_frame("nominal", 1'b0, 1'b0, -1, 0);

    load_frame(1'b0);
    run_frame("badtag", 1'b1, 1'b0, -1, 0);

    load_frame(1'b1);
    run_frame("order_spur", 1'b0, 1'b1, -1, 0);

    load_frame(1'b0);
    run_frame("midrst", 1'b0, 1'b0, 10, 0);
    load_frame(1'b0);
    run_frame("after_rst", 1'b0, 1'b0, -1, 0);

    load_frame(1'b0);
    run_frame("held", 1'b0, 1'b0, -1, 200);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/fsm_ascon_dec.md
FSM_ASCON_DEC -- requirements
Module: fsm_ascon_dec

Interface
REQ-001 SHALL have port clock_i, in, 1: single clock; all state changes on its rising edge.
REQ-002 SHALL have port reset_i, in, 1: reset, synchronous, active-high.
REQ-003 SHALL have port start_i, in, 1: level request to decrypt one frame.
REQ-004 SHALL have port cipher_i, in, 1472: ciphertext frame, block k = cipher_i[1471-64k -: 64], k=0..22.
REQ-005 SHALL have port tag_i, in, 128: received tag.
REQ-006 SHALL have port associate_data_i, in, 64: associated-data block.
REQ-007 SHALL have ports end_initialisation_i, end_associate_i, cipher_valid_i, end_cipher_i, end_tag_i, in, 1 each: ASCON core status pulses.
REQ-008 SHALL have port core_data_i, in, 64: plaintext block returned by core, sampled when cipher_valid_i=1.
REQ-009 SHALL have port tag_computed_i, in, 128: core tag, valid from end_tag_i onward.
REQ-010 SHALL have ports init_o, associate_data_o, finalisation_o, data_valid_o, out, 1 each: core control, same meaning as encrypt-side core control.
REQ-011 SHALL have port decrypt_o, out, 1: core mode select, 1 from INIT through WAIT_TAG.
REQ-012 SHALL have port data_o, out, 64: block presented to core.
REQ-013 SHALL have port plain_o, out, 1472: assembled plaintext, block k at the same bit position as cipher block k.
REQ-014 SHALL have ports done_o, tag_ok_o, out, 1 each: frame complete; tag matched.

Function
REQ-015 States: IDLE, INIT, WAIT_INIT, AD, AD_VALID, WAIT_AD, CT_SET, CT_WAIT_VALID, CT_GET, CT_WAIT_END, FINAL, WAIT_TAG, CHECK, DONE.
REQ-016 IDLE->INIT when start_i=1; INIT->WAIT_INIT unconditionally; WAIT_INIT->AD on end_initialisation_i.
REQ-017 AD->AD_VALID->WAIT_AD unconditionally; WAIT_AD->CT_SET on end_associate_i.
REQ-018 CT_SET->CT_WAIT_VALID; CT_WAIT_VALID->CT_GET on cipher_valid_i; CT_GET->CT_WAIT_END.
REQ-019 CT_WAIT_END on end_cipher_i: ->FINAL if blk_cnt=23 (after increment in CT_GET), else ->CT_SET.
REQ-020 FINAL->WAIT_TAG on cipher_valid_i; WAIT_TAG->CHECK on end_tag_i; CHECK->DONE unconditionally; DONE->IDLE when start_i=0.
REQ-021 blk_cnt: 5-bit, cleared in INIT, incremented by 1 in CT_GET only, never exceeds 23.
REQ-022 init_o=1 in INIT only; associate_data_o=1 in AD, AD_VALID; finalisation_o=1 in FINAL, WAIT_TAG.
REQ-023 data_valid_o=1 in AD_VALID, CT_SET, FINAL, WAIT_TAG; 0 elsewhere.
REQ-024 data_o=associate_data_i in AD..WAIT_AD; cipher block blk_cnt in CT_SET..CT_WAIT_END; 64'h8000_0000_0000_0000 in FINAL, WAIT_TAG; 0 elsewhere.
REQ-025 In CT_GET, core_data_i SHALL be written into plain_o block blk_cnt (pre-increment value); other blocks unchanged.
REQ-026 plain_o SHALL be cleared to 0 in INIT.
REQ-027 In CHECK, tag_ok_o SHALL register (tag_computed_i == tag_i), full 128-bit compare.
REQ-028 If tag_ok_o=0 on entering DONE, plain_o SHALL be cleared to 0 the same cycle.
REQ-029 done_o=1 in DONE only; tag_ok_o holds until next INIT, then clears.
REQ-030 Status pulses arriving in states not waiting for them SHALL be ignored.
REQ-031 start_i held high through DONE SHALL NOT restart; a new frame requires start_i low then high.

Reset
REQ-032 reset_i=1 at a clock edge SHALL force IDLE, blk_cnt=0, plain_o=0, tag_ok_o=0, all other outputs 0, from any state including mid-frame.
REQ-033 All outputs SHALL be registered or decoded from registered state only; no output depends combinationally on start_i.

Verification
REQ-034 Nominal: model core with 3-cycle latencies, matching tag -> 23 CT_GET cycles, plain_o = model plaintext, tag_ok_o=1, done_o=1 for one+ cycles.
REQ-035 Bad tag: tag_i bit 0 flipped -> tag_ok_o=0, plain_o=0 in DONE.
REQ-036 Block order: cipher_i block k = 64'h(k repeated) -> data_o sequence 0..22 then 64'h8000_0000_0000_0000.
REQ-037 Reset mid-frame: reset_i at blk_cnt=10 -> next cycle IDLE, plain_o=0; new start_i completes correctly.
REQ-038 Spurious pulses: end_cipher_i in CT_SET, end_tag_i in IDLE -> no state change.
REQ-039 Held start_i: start_i high 200 cycles -> exactly one frame, stays in DONE until start_i=0.
